// File: rtl/t_ff_counter_param.sv
// t_ff_counter_param: WIDTH-bit register with two run-time modes.
//   mode = 0 : bank of WIDTH independent T flip-flops toggled by mask t.
//   mode = 1 : modulo-MODULUS up/down counter, wrap or saturate, with a
//              registered terminal-count pulse tc.
// Optional build macro TFF_COUNTER_OVF_STICKY_EN adds a sticky overflow flag
// (ovf) that is set by every tc event and cleared by clear_ovf or reset.
// Single clock domain, synchronous active-high reset.
module t_ff_counter_param #(
    parameter int     WIDTH    = 8,
    parameter longint MODULUS  = 256,
    parameter int     SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mode,
    input  logic [WIDTH-1:0] t,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
`ifdef TFF_COUNTER_OVF_STICKY_EN
    input  logic             clear_ovf,
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    // Terminal value of the counter; MODULUS is kept 64-bit so that
    // MODULUS = 2^32 with WIDTH = 32 does not overflow.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);
    localparam logic             SAT     = (SATURATE != 0);

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;

    // Next-state: load beats enable step, otherwise hold with tc cleared.
    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (load) begin
            if (mode && (load_value > MAX_VAL)) begin
                q_d = MAX_VAL;
            end else begin
                q_d = load_value;
            end
        end else if (enable) begin
            if (!mode) begin
                q_d = q_q ^ t;
            end else if (up) begin
                // Out-of-range values (left over from bank mode) count as terminal.
                if (q_q < MAX_VAL) begin
                    q_d = q_q + 1'b1;
                end else begin
                    q_d  = SAT ? MAX_VAL : '0;
                    tc_d = 1'b1;
                end
            end else begin
                if (q_q > MAX_VAL) begin
                    // Re-enter the legal range from the top, not a terminal event.
                    q_d = MAX_VAL;
                end else if (q_q == '0) begin
                    q_d  = SAT ? '0 : MAX_VAL;
                    tc_d = 1'b1;
                end else begin
                    q_d = q_q - 1'b1;
                end
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign q  = q_q;
    assign tc = tc_q;

`ifdef TFF_COUNTER_OVF_STICKY_EN
    logic ovf_q, ovf_d;

    // Sticky flag: a tc event on the same edge as clear_ovf keeps it set.
    always_comb begin
        ovf_d = tc_d | (ovf_q & ~clear_ovf);
    end

    // Sticky flag register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_t_ff_counter_param.sv
// Directed bench for t_ff_counter_param: two instances with WIDTH=4,
// MODULUS=10, one wrapping (SATURATE=0) and one saturating (SATURATE=1),
// driven by the same inputs. Expected values are hand-computed.
module tb_t_ff_counter_param;

    logic       clk = 1'b0;
    logic       reset, enable, mode, up, load;
    logic [3:0] t, load_value;
    logic [3:0] qw, qs;
    logic       tcw, tcs;
`ifdef TFF_COUNTER_OVF_STICKY_EN
    logic       clear_ovf;
    logic       ovfw, ovfs;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    t_ff_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .t(t),
        .up(up), .load(load), .load_value(load_value),
`ifdef TFF_COUNTER_OVF_STICKY_EN
        .clear_ovf(clear_ovf), .ovf(ovfw),
`endif
        .q(qw), .tc(tcw)
    );

    t_ff_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .t(t),
        .up(up), .load(load), .load_value(load_value),
`ifdef TFF_COUNTER_OVF_STICKY_EN
        .clear_ovf(clear_ovf), .ovf(ovfs),
`endif
        .q(qs), .tc(tcs)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_both(input string tag, input logic [3:0] eqw, input logic etcw,
                            input logic [3:0] eqs, input logic etcs);
        chk({tag, " qw"}, 32'(qw), 32'(eqw));
        chk({tag, " tcw"}, 32'(tcw), 32'(etcw));
        chk({tag, " qs"}, 32'(qs), 32'(eqs));
        chk({tag, " tcs"}, 32'(tcs), 32'(etcs));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; mode = 1'b0; up = 1'b1; load = 1'b0;
        t = 4'd0; load_value = 4'd0;
`ifdef TFF_COUNTER_OVF_STICKY_EN
        clear_ovf = 1'b0;
`endif
        step();
        chk_both("reset", 4'd0, 1'b0, 4'd0, 1'b0);
`ifdef TFF_COUNTER_OVF_STICKY_EN
        chk("reset ovfw", 32'(ovfw), 32'd0);
        chk("reset ovfs", 32'(ovfs), 32'd0);
`endif
        reset = 1'b0;

        // Up count for 12 edges: wrap gives 1..9,0,1,2; saturate sticks at 9.
        mode = 1'b1; up = 1'b1; enable = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk_both("up_count", 4'((i == 10) ? 0 : (i > 10 ? i - 10 : i)), (i == 10),
                     4'((i >= 9) ? 9 : i), (i >= 10));
        end

        // Down count from 0.
        do_reset();
        up = 1'b0;
        step(); chk_both("down1", 4'd9, 1'b1, 4'd0, 1'b1);
        step(); chk_both("down2", 4'd8, 1'b0, 4'd0, 1'b1);
        step(); chk_both("down3", 4'd7, 1'b0, 4'd0, 1'b1);

        // Bank mode toggling and hold.
        do_reset();
        mode = 1'b0; t = 4'b1010; enable = 1'b1;
        step(); chk_both("bank1", 4'b1010, 1'b0, 4'b1010, 1'b0);
        step(); chk_both("bank2", 4'b0000, 1'b0, 4'b0000, 1'b0);
        enable = 1'b0; t = 4'b1111;
        step(); chk_both("bank_hold", 4'b0000, 1'b0, 4'b0000, 1'b0);

        // Loads: clamped in counter mode, raw in bank mode, load beats enable.
        mode = 1'b1; load = 1'b1; load_value = 4'd13;
        step(); chk_both("load_clamp", 4'd9, 1'b0, 4'd9, 1'b0);
        enable = 1'b1; up = 1'b1; load_value = 4'd3;
        step(); chk_both("load_vs_en", 4'd3, 1'b0, 4'd3, 1'b0);
        mode = 1'b0; enable = 1'b0; load_value = 4'd13;
        step(); chk_both("load_bank", 4'd13, 1'b0, 4'd13, 1'b0);

        // Out-of-range value from bank mode, then counter mode up / down.
        load_value = 4'd15;
        step(); chk_both("load_15", 4'd15, 1'b0, 4'd15, 1'b0);
        load = 1'b0; mode = 1'b1; up = 1'b1; enable = 1'b1;
        step(); chk_both("oor_up", 4'd0, 1'b1, 4'd9, 1'b1);
        mode = 1'b0; load = 1'b1; enable = 1'b0;
        step(); chk_both("load_15b", 4'd15, 1'b0, 4'd15, 1'b0);
        load = 1'b0; mode = 1'b1; up = 1'b0; enable = 1'b1;
        step(); chk_both("oor_down", 4'd9, 1'b0, 4'd9, 1'b0);

        // Reset mid-count at q=7 overrides enable; count resumes from 0.
        do_reset();
        up = 1'b1;
        repeat (7) step();
        chk_both("count7", 4'd7, 1'b0, 4'd7, 1'b0);
        reset = 1'b1;
        step(); chk_both("mid_reset", 4'd0, 1'b0, 4'd0, 1'b0);
`ifdef TFF_COUNTER_OVF_STICKY_EN
        chk("mid_reset ovfw", 32'(ovfw), 32'd0);
`endif
        reset = 1'b0;
        step(); chk_both("resume", 4'd1, 1'b0, 4'd1, 1'b0);

`ifdef TFF_COUNTER_OVF_STICKY_EN
        // Sticky overflow: set by wrap, cleared by clear_ovf, set wins on tie.
        do_reset();
        repeat (9) step();
        chk("pre_wrap ovfw", 32'(ovfw), 32'd0);
        step();
        chk("wrap ovfw", 32'(ovfw), 32'd1);
        chk("wrap ovfs", 32'(ovfs), 32'd1);
        clear_ovf = 1'b1;
        step();
        chk("clear ovfw", 32'(ovfw), 32'd0);
        chk("clear_vs_tc ovfs", 32'(ovfs), 32'd1);
        clear_ovf = 1'b0;
        repeat (8) step();
        chk("q9 qw", 32'(qw), 32'd9);
        clear_ovf = 1'b1;
        step();
        chk("wrap_clear qw", 32'(qw), 32'd0);
        chk("wrap_clear ovfw", 32'(ovfw), 32'd1);
        clear_ovf = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
